ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the integer ALU. Registers one decoded instruction, resolves forwarding from MEM and WB, and applies operand muxing. Drives the ALU's operand_a_i, operand_b_i and alu_op_i. Handles load-use stall, downstream backpressure and flush through a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  kill held instruction (branch/trap redirect)
id_valid_i  in  1  ID presents an instruction
id_ready_o  out  1  stage accepts the ID instruction this cycle
id_pc_i  in  XLEN  instruction PC
id_rs1_addr_i / id_rs2_addr_i  in  RA_W  source register indices
id_rs1_data_i / id_rs2_data_i  in  XLEN  register file read data
id_imm_i  in  XLEN  sign-extended immediate
id_a_sel_i  in  2  operand A source: 0=rs1, 1=pc, 2=zero, 3=zero
id_b_sel_i  in  1  operand B source: 0=rs2, 1=imm
id_alu_op_i  in  4  ALU opcode, passed through unchanged (0=ADD … A=LUI)
id_rd_addr_i  in  RA_W  destination register
id_rd_wen_i  in  1  destination write enable
mem_rd_addr_i, mem_rd_wen_i, mem_rd_data_i, mem_is_load_i  in  RA_W/1/XLEN/1  MEM-stage writeback bus
wb_rd_addr_i, wb_rd_wen_i, wb_rd_data_i  in  RA_W/1/XLEN  WB-stage writeback bus
ex_ready_i  in  1  EX consumer accepts this cycle
ex_valid_o  out  1  operands valid for the ALU
operand_a_o / operand_b_o  out  XLEN  ALU operands
alu_op_o  out  4  ALU opcode
ex_rs2_data_o  out  XLEN  forwarded rs2 value (store data)
ex_rd_addr_o / ex_rd_wen_o  out  RA_W/1  destination passthrough
load_use_stall_o  out  1  hazard indicator to ID/PC logic

Behaviour:
- Reset (async assert, sync deassert at the next clk_i edge after release): valid_q=0, state=EMPTY, all held fields=0. Outputs: ex_valid_o=0, operand_a_o=0, operand_b_o=0, alu_op_o=0, ex_rs2_data_o=0, ex_rd_*=0, load_use_stall_o=0, id_ready_o=1.
- Single-entry register. fire_ex = ex_valid_o & ex_ready_i. id_ready_o = ~valid_q | fire_ex. Capture occurs when id_valid_i & id_ready_o & ~flush_i.
- Forwarding is combinational on held rs values, applied per source:
  - If the MEM bus matches (mem_rd_wen_i, mem_rd_addr_i == rs, rs != 0): take mem_rd_data_i.
  - Else if the WB bus matches: take wb_rd_data_i.
  - Else: take the held register value.
  - MEM has priority over WB. x0 is never forwarded; it always reads the held value.
- Refresh: every cycle valid_q=1 and not fire_ex, the held rs1/rs2 data are overwritten with their forwarded values. Operands stay correct after the producer retires during a stall.
- Load-use hazard: lu = valid_q & mem_is_load_i & mem_rd_wen_i & mem_rd_addr_i != 0 & mem_rd_addr_i matches a used source.
  - Used source: rs1 when a_sel=0, rs2 always (store data).
  - While lu=1: ex_valid_o=0 and load_use_stall_o=1.
  - The next cycle the load sits in WB, so forwarding resolves the operand and ex_valid_o rises.
  - Latency: 1 cycle in the normal case, +1 on a load-use.
- FSM:
  - EMPTY → FULL on capture.
  - FULL → LU_WAIT when lu=1. LU_WAIT → FULL when lu=0.
  - FULL → EMPTY on fire_ex without a new capture. FULL → FULL on fire_ex with a simultaneous capture (back-to-back, full throughput).
  - Any state → EMPTY on flush_i.
- Operand A by a_sel: forwarded rs1 / held pc / 0 / 0. Operand B by b_sel: forwarded rs2 / held imm. ex_rs2_data_o is always the forwarded rs2.
- Backpressure: when ex_ready_i=0 and ex_valid_o=1, all outputs remain stable except for refresh. Refresh does not change the values driven, because the value before refresh equals the forwarded value.
- Flush: valid_q clears at the next edge. Flush wins over a simultaneous capture, and id_valid_i is ignored that cycle. When flush_i=1, ex_valid_o is also forced to 0 combinationally in the same cycle.
- Reset mid-stall: the entry is dropped immediately and the stage returns to the reset state.

Test Plan:
- Back-to-back independent ADD/SUB, ex_ready_i=1 → ex_valid_o high every cycle after the first. operand_a_o=5, operand_b_o=3, alu_op_o=0 then 1. No bubbles.
- EX holds x1 with a_sel=0, MEM writing x1=0xDEAD_BEEF, WB writing x1=0x1234 → operand_a_o=0xDEADBEEF (MEM priority). Repeat with rd=x0 → held register value used.
- Load x2 in MEM, EX instruction uses x2 → cycle 1: ex_valid_o=0, load_use_stall_o=1, id_ready_o=0. Cycle 2: load in WB with 0x55 → ex_valid_o=1, operand_b_o=0x55.
- ex_ready_i=0 for 3 cycles while the producer of rs1 (0xA5A5) passes MEM, then WB, then retires → operand_a_o=0xA5A5 on every cycle and at the eventual fire.
- flush_i asserted while FULL and id_valid_i=1 → ex_valid_o=0 the same cycle. Next cycle state is EMPTY, and the ID instruction is not captured.
- rst_i pulsed asynchronously between edges during LU_WAIT → all outputs 0 immediately. id_ready_o=1 after release.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards from MEM/WB,
// muxes ALU operands and stalls on load-use hazards.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_EMPTY   | no instruction held
//   S_FULL    | instruction held, operands resolvable
//   S_LU_WAIT | instruction held, waiting one cycle for a load in MEM
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,

    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [1:0]      id_a_sel_i,
    input  logic            id_b_sel_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_rd_wen_i,

    input  logic [RA_W-1:0] mem_rd_addr_i,
    input  logic            mem_rd_wen_i,
    input  logic [XLEN-1:0] mem_rd_data_i,
    input  logic            mem_is_load_i,

    input  logic [RA_W-1:0] wb_rd_addr_i,
    input  logic            wb_rd_wen_i,
    input  logic [XLEN-1:0] wb_rd_data_i,

    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] operand_a_o,
    output logic [XLEN-1:0] operand_b_o,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_rd_wen_o,
    output logic            load_use_stall_o
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FULL    = 2'd1,
        S_LU_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [1:0]      r_a_sel;
    logic            r_b_sel;
    logic [3:0]      r_alu_op;
    logic [RA_W-1:0] r_rd_addr;
    logic            r_rd_wen;

    logic            w_valid_q;
    logic            w_mem_hit_rs1;
    logic            w_mem_hit_rs2;
    logic            w_wb_hit_rs1;
    logic            w_wb_hit_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_lu;
    logic            w_fire;
    logic            w_capture;

    assign w_valid_q = (r_state != S_EMPTY);

    // x0 never matches, so it always reads the held value
    assign w_mem_hit_rs1 = mem_rd_wen_i && (mem_rd_addr_i == r_rs1_addr) && (r_rs1_addr != '0);
    assign w_mem_hit_rs2 = mem_rd_wen_i && (mem_rd_addr_i == r_rs2_addr) && (r_rs2_addr != '0);
    assign w_wb_hit_rs1  = wb_rd_wen_i  && (wb_rd_addr_i  == r_rs1_addr) && (r_rs1_addr != '0);
    assign w_wb_hit_rs2  = wb_rd_wen_i  && (wb_rd_addr_i  == r_rs2_addr) && (r_rs2_addr != '0);

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (w_mem_hit_rs1) begin
            w_fwd_rs1 = mem_rd_data_i;
        end else if (w_wb_hit_rs1) begin
            w_fwd_rs1 = wb_rd_data_i;
        end
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (w_mem_hit_rs2) begin
            w_fwd_rs2 = mem_rd_data_i;
        end else if (w_wb_hit_rs2) begin
            w_fwd_rs2 = wb_rd_data_i;
        end
    end

    // rs2 always counts as used because it is also the store data
    assign w_lu = w_valid_q && mem_is_load_i &&
                  ((w_mem_hit_rs1 && (r_a_sel == 2'd0)) || w_mem_hit_rs2);

    assign ex_valid_o       = w_valid_q && !w_lu && !flush_i;
    assign w_fire           = ex_valid_o && ex_ready_i;
    assign id_ready_o       = !w_valid_q || w_fire;
    assign w_capture        = id_valid_i && id_ready_o && !flush_i;
    assign load_use_stall_o = w_lu;

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_capture) begin
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL, S_LU_WAIT: begin
                    if (w_fire) begin
                        w_state_nxt = w_capture ? S_FULL : S_EMPTY;
                    end else if (w_lu) begin
                        w_state_nxt = S_LU_WAIT;
                    end else begin
                        w_state_nxt = S_FULL;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_a_sel    <= '0;
            r_b_sel    <= 1'b0;
            r_alu_op   <= '0;
            r_rd_addr  <= '0;
            r_rd_wen   <= 1'b0;
        end else if (w_capture) begin
            r_pc       <= id_pc_i;
            r_imm      <= id_imm_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
            r_rs1_addr <= id_rs1_addr_i;
            r_rs2_addr <= id_rs2_addr_i;
            r_a_sel    <= id_a_sel_i;
            r_b_sel    <= id_b_sel_i;
            r_alu_op   <= id_alu_op_i;
            r_rd_addr  <= id_rd_addr_i;
            r_rd_wen   <= id_rd_wen_i;
        end else if (w_valid_q && !w_fire) begin
            // Latch forwarded values so they survive the producer retiring
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end
    end

    always_comb begin
        operand_a_o = '0;
        case (r_a_sel)
            2'd0:    operand_a_o = w_fwd_rs1;
            2'd1:    operand_a_o = r_pc;
            default: operand_a_o = '0;
        endcase
    end

    assign operand_b_o   = r_b_sel ? r_imm : w_fwd_rs2;
    assign ex_rs2_data_o = w_fwd_rs2;
    assign alu_op_o      = r_alu_op;
    assign ex_rd_addr_o  = r_rd_addr;
    assign ex_rd_wen_o   = r_rd_wen;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: vector table through a scoreboard,
// plus directed back-to-back, load-use, backpressure, flush and reset sequences.
module tb_ex_operand_stage;

    typedef struct {
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        instr_t      ins;
        logic [4:0]  ma;
        logic        mw;
        logic [31:0] md;
        logic [4:0]  wa;
        logic        ww;
        logic [31:0] wd;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [31:0] id_pc_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i;
    logic [31:0] id_imm_i;
    logic [1:0]  id_a_sel_i;
    logic        id_b_sel_i;
    logic [3:0]  id_alu_op_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_wen_i;
    logic [4:0]  mem_rd_addr_i;
    logic        mem_rd_wen_i;
    logic [31:0] mem_rd_data_i;
    logic        mem_is_load_i;
    logic [4:0]  wb_rd_addr_i;
    logic        wb_rd_wen_i;
    logic [31:0] wb_rd_data_i;
    logic        ex_ready_i;
    logic        ex_valid_o;
    logic [31:0] operand_a_o, operand_b_o, ex_rs2_data_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_rd_wen_o;
    logic        load_use_stall_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_a_sel_i(id_a_sel_i), .id_b_sel_i(id_b_sel_i),
        .id_alu_op_i(id_alu_op_i), .id_rd_addr_i(id_rd_addr_i), .id_rd_wen_i(id_rd_wen_i),
        .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wen_i(mem_rd_wen_i),
        .mem_rd_data_i(mem_rd_data_i), .mem_is_load_i(mem_is_load_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wen_i(wb_rd_wen_i), .wb_rd_data_i(wb_rd_data_i),
        .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .alu_op_o(alu_op_o),
        .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wen_o(ex_rd_wen_o),
        .load_use_stall_o(load_use_stall_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic instr_t mk_ins(logic [1:0] as, logic bs, logic [31:0] pc,
                                      logic [4:0] r1a, logic [31:0] r1d,
                                      logic [4:0] r2a, logic [31:0] r2d,
                                      logic [31:0] imm, logic [3:0] op, logic [4:0] rd);
        instr_t x;
        x.a_sel = as; x.b_sel = bs; x.pc = pc;
        x.rs1a = r1a; x.rs1d = r1d; x.rs2a = r2a; x.rs2d = r2d;
        x.imm = imm; x.op = op; x.rd = rd;
        return x;
    endfunction

    function automatic exp_t mk_exp(logic [31:0] a, logic [31:0] b, logic [31:0] rs2,
                                    logic [3:0] op, logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.rs2 = rs2; e.op = op; e.rd = rd;
        return e;
    endfunction

    task automatic put_id(input logic v, input instr_t x);
        id_valid_i    = v;
        id_a_sel_i    = x.a_sel;
        id_b_sel_i    = x.b_sel;
        id_pc_i       = x.pc;
        id_rs1_addr_i = x.rs1a;
        id_rs1_data_i = x.rs1d;
        id_rs2_addr_i = x.rs2a;
        id_rs2_data_i = x.rs2d;
        id_imm_i      = x.imm;
        id_alu_op_i   = x.op;
        id_rd_addr_i  = x.rd;
        id_rd_wen_i   = 1'b1;
    endtask

    task automatic set_mem(input logic [4:0] a, input logic w, input logic [31:0] d, input logic ld);
        mem_rd_addr_i = a; mem_rd_wen_i = w; mem_rd_data_i = d; mem_is_load_i = ld;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic w, input logic [31:0] d);
        wb_rd_addr_i = a; wb_rd_wen_i = w; wb_rd_data_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ALU handoff must match the oldest expected record
    always @(negedge clk) begin
        if (!rst_i && ex_valid_o && ex_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fire actual=fire required=no_fire a=%h", operand_a_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_operand_a", operand_a_o, e.a);
                chk("sb_operand_b", operand_b_o, e.b);
                chk("sb_rs2_data", ex_rs2_data_o, e.rs2);
                chk("sb_alu_op", {28'd0, alu_op_o}, {28'd0, e.op});
                chk("sb_rd_addr", {27'd0, ex_rd_addr_o}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        instr_t nop_i;
        instr_t x;
        nop_i = mk_ins(2'd0, 1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 4'h0, 5'd0);

        vecs[0] = '{ins: mk_ins(0, 0, 32'h100, 3, 32'd5, 4, 32'd3, 32'h0, 4'h0, 10),
                    ma: 0, mw: 0, md: 0, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'd5, 32'd3, 32'd3, 4'h0, 10)};
        vecs[1] = '{ins: mk_ins(0, 0, 32'h104, 3, 32'd5, 4, 32'd3, 32'h0, 4'h1, 11),
                    ma: 0, mw: 0, md: 0, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'd5, 32'd3, 32'd3, 4'h1, 11)};
        vecs[2] = '{ins: mk_ins(0, 1, 32'h108, 1, 32'h11, 5, 32'd7, 32'h10, 4'h0, 12),
                    ma: 1, mw: 1, md: 32'hDEADBEEF, wa: 1, ww: 1, wd: 32'h1234,
                    e: mk_exp(32'hDEADBEEF, 32'h10, 32'd7, 4'h0, 12)};
        vecs[3] = '{ins: mk_ins(0, 0, 32'h10C, 0, 32'h77, 0, 32'h66, 32'h0, 4'h2, 13),
                    ma: 0, mw: 1, md: 32'hDEAD, wa: 0, ww: 1, wd: 32'h1234,
                    e: mk_exp(32'h77, 32'h66, 32'h66, 4'h2, 13)};
        vecs[4] = '{ins: mk_ins(0, 0, 32'h110, 8, 32'd1, 6, 32'd1, 32'h0, 4'h3, 14),
                    ma: 0, mw: 0, md: 0, wa: 6, ww: 1, wd: 32'hCAFE,
                    e: mk_exp(32'd1, 32'hCAFE, 32'hCAFE, 4'h3, 14)};
        vecs[5] = '{ins: mk_ins(1, 1, 32'h1000, 3, 32'd5, 4, 32'd3, 32'd4, 4'h0, 15),
                    ma: 0, mw: 0, md: 0, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'h1000, 32'd4, 32'd3, 4'h0, 15)};
        vecs[6] = '{ins: mk_ins(2, 0, 32'h200, 1, 32'd9, 4, 32'd3, 32'h0, 4'h5, 16),
                    ma: 1, mw: 1, md: 32'hBAD, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'h0, 32'd3, 32'd3, 4'h5, 16)};
        vecs[7] = '{ins: mk_ins(3, 1, 32'h204, 1, 32'd9, 4, 32'd3, 32'hFFFF_FFF0, 4'hA, 17),
                    ma: 0, mw: 0, md: 0, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'h0, 32'hFFFF_FFF0, 32'd3, 4'hA, 17)};
        vecs[8] = '{ins: mk_ins(0, 0, 32'h208, 9, 32'd2, 9, 32'd3, 32'h0, 4'h6, 18),
                    ma: 9, mw: 0, md: 32'h111, wa: 9, ww: 1, wd: 32'h222,
                    e: mk_exp(32'h222, 32'h222, 32'h222, 4'h6, 18)};
        vecs[9] = '{ins: mk_ins(0, 1, 32'h20C, 4, 32'd5, 9, 32'd3, 32'h8, 4'h7, 19),
                    ma: 9, mw: 1, md: 32'h333, wa: 0, ww: 0, wd: 0,
                    e: mk_exp(32'd5, 32'h8, 32'h333, 4'h7, 19)};

        rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
        put_id(1'b0, nop_i);
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);

        // Reset state
        @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready_o}, 32'd1);
        chk("rst_operand_a", operand_a_o, 32'd0);
        chk("rst_operand_b", operand_b_o, 32'd0);
        chk("rst_stall", {31'd0, load_use_stall_o}, 32'd0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        // Vector table: capture, then present the forwarding buses on the fire cycle
        for (int i = 0; i < 10; i++) begin
            put_id(1'b1, vecs[i].ins);
            set_mem(0, 0, 0, 0);
            set_wb(0, 0, 0);
            sb.push_back(vecs[i].e);
            next_cycle();
            put_id(1'b0, nop_i);
            set_mem(vecs[i].ma, vecs[i].mw, vecs[i].md, 1'b0);
            set_wb(vecs[i].wa, vecs[i].ww, vecs[i].wd);
            @(negedge clk);
            chk("vec_ex_valid", {31'd0, ex_valid_o}, 32'd1);
            next_cycle();
        end
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);

        // Back-to-back ADD then SUB, no bubble
        put_id(1'b1, mk_ins(0, 0, 32'h300, 3, 32'd5, 4, 32'd3, 32'h0, 4'h0, 20));
        sb.push_back(mk_exp(32'd5, 32'd3, 32'd3, 4'h0, 20));
        next_cycle();
        put_id(1'b1, mk_ins(0, 0, 32'h304, 3, 32'd5, 4, 32'd3, 32'h0, 4'h1, 21));
        sb.push_back(mk_exp(32'd5, 32'd3, 32'd3, 4'h1, 21));
        @(negedge clk);
        chk("b2b_valid_1", {31'd0, ex_valid_o}, 32'd1);
        chk("b2b_id_ready", {31'd0, id_ready_o}, 32'd1);
        next_cycle();
        put_id(1'b0, nop_i);
        @(negedge clk);
        chk("b2b_valid_2", {31'd0, ex_valid_o}, 32'd1);
        next_cycle();
        chk("b2b_drained", sb.size(), 32'd0);

        // Load-use on rs2 (x2)
        put_id(1'b1, mk_ins(0, 0, 32'h400, 3, 32'd5, 2, 32'h0, 32'h0, 4'h0, 22));
        sb.push_back(mk_exp(32'd5, 32'h55, 32'h55, 4'h0, 22));
        next_cycle();
        put_id(1'b1, mk_ins(0, 0, 32'h404, 3, 32'd1, 4, 32'd1, 32'h0, 4'h0, 23));
        set_mem(2, 1, 32'h999, 1);
        @(negedge clk);
        chk("lu_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("lu_stall", {31'd0, load_use_stall_o}, 32'd1);
        chk("lu_id_ready", {31'd0, id_ready_o}, 32'd0);
        next_cycle();
        put_id(1'b0, nop_i);
        set_mem(0, 0, 0, 0);
        set_wb(2, 1, 32'h55);
        @(negedge clk);
        chk("lu_resolved_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("lu_resolved_stall", {31'd0, load_use_stall_o}, 32'd0);
        next_cycle();
        set_wb(0, 0, 0);

        // Backpressure while rs1 producer passes MEM, WB, then retires
        put_id(1'b1, mk_ins(0, 1, 32'h500, 7, 32'h0, 0, 32'h0, 32'd2, 4'h4, 24));
        sb.push_back(mk_exp(32'hA5A5, 32'd2, 32'h0, 4'h4, 24));
        next_cycle();
        put_id(1'b0, nop_i);
        ex_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_mem(7, (c == 0), 32'hA5A5, 0);
            set_wb(7, (c == 1), 32'hA5A5);
            @(negedge clk);
            chk("bp_operand_a", operand_a_o, 32'hA5A5);
            chk("bp_ex_valid", {31'd0, ex_valid_o}, 32'd1);
            next_cycle();
        end
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);
        ex_ready_i = 1'b1;
        @(negedge clk);
        next_cycle();
        chk("bp_drained", sb.size(), 32'd0);

        // Flush while FULL with a competing ID instruction
        put_id(1'b1, mk_ins(0, 0, 32'h600, 3, 32'd5, 4, 32'd3, 32'h0, 4'h2, 25));
        next_cycle();
        put_id(1'b1, mk_ins(0, 0, 32'h604, 3, 32'd6, 4, 32'd7, 32'h0, 4'h3, 26));
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_same_cycle", {31'd0, ex_valid_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        put_id(1'b0, nop_i);
        @(negedge clk);
        chk("flush_empty_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("flush_empty_ready", {31'd0, id_ready_o}, 32'd1);
        next_cycle();

        // Asynchronous reset during LU_WAIT
        put_id(1'b1, mk_ins(0, 0, 32'h700, 2, 32'h9, 4, 32'd3, 32'h0, 4'h9, 27));
        next_cycle();
        put_id(1'b0, nop_i);
        set_mem(2, 1, 32'h777, 1);
        @(negedge clk);
        chk("rlu_stall", {31'd0, load_use_stall_o}, 32'd1);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        chk("rlu_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rlu_stall_clr", {31'd0, load_use_stall_o}, 32'd0);
        chk("rlu_operand_a", operand_a_o, 32'd0);
        chk("rlu_operand_b", operand_b_o, 32'd0);
        chk("rlu_alu_op", {28'd0, alu_op_o}, 32'd0);
        chk("rlu_rd_addr", {27'd0, ex_rd_addr_o}, 32'd0);
        chk("rlu_rs2_data", ex_rs2_data_o, 32'd0);
        #2;
        rst_i = 1'b0;
        set_mem(0, 0, 0, 0);
        @(negedge clk);
        chk("rlu_id_ready", {31'd0, id_ready_o}, 32'd1);
        chk("rlu_valid_after", {31'd0, ex_valid_o}, 32'd0);
        next_cycle();

        chk("sb_pending", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
